// File: rtl/i2c_eeprom_master.sv
// I2C master for byte-addressed EEPROMs: write, random read and current-address read.
// Optional clock stretching support when I2C_CLKSTRETCH_EN is defined.
module i2c_eeprom_master (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       rw_i,
  input  logic       ur_i,
  input  logic [6:0] devadr_i,
  input  logic [7:0] regadr_i,
  input  logic [4:0] datnum_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       busy_o,
  output logic       deverr_o,
  output logic       dvalid_o,
  output logic       newdat_o,
  inout  wire        scl,
  inout  wire        sda
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_TXBYTE = 3'd2;
  localparam logic [2:0] S_RXACK  = 3'd3;
  localparam logic [2:0] S_RXBYTE = 3'd4;
  localparam logic [2:0] S_TXACK  = 3'd5;
  localparam logic [2:0] S_RSTART = 3'd6;
  localparam logic [2:0] S_STOP   = 3'd7;

  // Which byte of the frame is currently on the wire
  localparam logic [1:0] G_ADDRW = 2'd0;
  localparam logic [1:0] G_REG   = 2'd1;
  localparam logic [1:0] G_ADDRR = 2'd2;
  localparam logic [1:0] G_DATA  = 2'd3;

  logic [2:0] r_state;
  logic [1:0] r_phase;
  logic [2:0] r_bit;
  logic [4:0] r_byte;
  logic [1:0] r_stage;
  logic [7:0] r_shift;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [4:0] r_num;
  logic       r_nack;
  logic       r_deverr;
  logic       r_dvalid;
  logic [7:0] r_dat;

  logic w_scl_low;
  logic w_sda_low;
  logic w_load;
  logic w_txbit;
  logic w_last;
  logic w_stall;
  logic w_sda_in;

  assign w_sda_in = sda;
  assign w_load   = (r_state == S_TXBYTE) && (r_stage == G_DATA) &&
                    (r_bit == 3'd7) && (r_phase == 2'd0);
  // First data bit goes out straight from dat_i while it is being captured
  assign w_txbit  = w_load ? dat_i[7] : r_shift[7];
  assign w_last   = (5'(r_byte + 5'd1) == r_num);

`ifdef I2C_CLKSTRETCH_EN
  assign w_stall = (r_state != S_IDLE) && (r_phase == 2'd1) && (scl == 1'b0);
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_scl_low = 1'b0;
    w_sda_low = 1'b0;
    case (r_state)
      S_START: begin
        w_sda_low = (r_phase != 2'd0);
        w_scl_low = (r_phase == 2'd3);
      end
      S_RSTART: w_scl_low = (r_phase == 2'd0);
      S_TXBYTE: begin
        w_scl_low = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_low = ~w_txbit;
      end
      S_RXACK, S_RXBYTE: w_scl_low = (r_phase == 2'd0) || (r_phase == 2'd3);
      S_TXACK: begin
        w_scl_low = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_low = ~w_last;
      end
      S_STOP: begin
        w_scl_low = (r_phase == 2'd0);
        w_sda_low = (r_phase <= 2'd1);
      end
      default: ;
    endcase
  end

  assign scl      = w_scl_low ? 1'b0 : 1'bz;
  assign sda      = w_sda_low ? 1'b0 : 1'bz;
  assign busy_o   = (r_state != S_IDLE);
  assign newdat_o = w_load;
  assign dvalid_o = r_dvalid;
  assign deverr_o = r_deverr;
  assign dat_o    = r_dat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_stage  <= G_ADDRW;
      r_shift  <= '0;
      r_rw     <= 1'b0;
      r_dev    <= '0;
      r_reg    <= '0;
      r_num    <= '0;
      r_nack   <= 1'b0;
      r_deverr <= 1'b0;
      r_dvalid <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_dvalid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_phase <= '0;
        if (enable_i) begin
          r_rw     <= rw_i;
          r_dev    <= devadr_i;
          r_reg    <= regadr_i;
          r_num    <= datnum_i;
          r_deverr <= 1'b0;
          r_bit    <= 3'd7;
          r_byte   <= '0;
          r_state  <= S_START;
          if (rw_i && !ur_i) begin
            r_stage <= G_ADDRR;
            r_shift <= {devadr_i, 1'b1};
          end else begin
            r_stage <= G_ADDRW;
            r_shift <= {devadr_i, 1'b0};
          end
        end
      end else begin
        if (!w_stall) r_phase <= r_phase + 2'd1;
        case (r_state)
          S_START:  if (r_phase == 2'd3) begin r_bit <= 3'd7; r_state <= S_TXBYTE; end
          S_RSTART: if (r_phase == 2'd3) r_state <= S_START;
          S_STOP:   if (r_phase == 2'd3) r_state <= S_IDLE;
          S_TXBYTE: begin
            if (w_load) r_shift <= dat_i;
            if (r_phase == 2'd3) begin
              r_shift <= {r_shift[6:0], 1'b0};
              if (r_bit == 3'd0) r_state <= S_RXACK;
              else               r_bit   <= r_bit - 3'd1;
            end
          end
          S_RXACK: begin
            if (r_phase == 2'd2) r_nack <= w_sda_in;
            if (r_phase == 2'd3) begin
              r_bit <= 3'd7;
              if (r_nack) begin
                r_deverr <= 1'b1;
                r_state  <= S_STOP;
              end else begin
                case (r_stage)
                  G_ADDRW: begin
                    r_shift <= r_reg;
                    r_stage <= G_REG;
                    r_state <= S_TXBYTE;
                  end
                  G_REG: begin
                    if (r_rw) begin
                      r_shift <= {r_dev, 1'b1};
                      r_stage <= G_ADDRR;
                      r_state <= S_RSTART;
                    end else if (r_num == 5'd0) begin
                      r_state <= S_STOP;
                    end else begin
                      r_stage <= G_DATA;
                      r_byte  <= '0;
                      r_state <= S_TXBYTE;
                    end
                  end
                  G_ADDRR: begin
                    r_byte  <= '0;
                    r_state <= (r_num == 5'd0) ? S_STOP : S_RXBYTE;
                  end
                  default: begin
                    if (w_last) r_state <= S_STOP;
                    else begin
                      r_byte  <= r_byte + 5'd1;
                      r_state <= S_TXBYTE;
                    end
                  end
                endcase
              end
            end
          end
          S_RXBYTE: begin
            if (r_phase == 2'd2) begin
              r_shift <= {r_shift[6:0], w_sda_in};
              if (r_bit == 3'd0) begin
                r_dat    <= {r_shift[6:0], w_sda_in};
                r_dvalid <= 1'b1;
              end
            end
            if (r_phase == 2'd3) begin
              if (r_bit == 3'd0) r_state <= S_TXACK;
              else               r_bit   <= r_bit - 3'd1;
            end
          end
          S_TXACK: begin
            if (r_phase == 2'd3) begin
              if (w_last) r_state <= S_STOP;
              else begin
                r_byte  <= r_byte + 5'd1;
                r_bit   <= 3'd7;
                r_state <= S_RXBYTE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Bench for i2c_eeprom_master: cycle-sampled bus slave model plus scoreboards of
// expected bus tokens and received bytes. Stretch case runs when I2C_CLKSTRETCH_EN is set.
module tb_i2c_eeprom_master;

  localparam int T_S    = 256;
  localparam int T_P    = 257;
  localparam int T_ACK  = 258;
  localparam int T_NACK = 259;

  logic       clk = 1'b0;
  logic       rst_n, enable, rw, ur;
  logic [6:0] devadr;
  logic [7:0] regadr, dat_i;
  logic [4:0] datnum;
  wire  [7:0] dat_o;
  wire        busy, deverr, dvalid, newdat;
  wire        scl, sda;
  logic       s_sda_low = 1'b0;
  logic       s_scl_low = 1'b0;

  always #5 clk = ~clk;

  pullup (scl);
  pullup (sda);
  assign sda = s_sda_low ? 1'b0 : 1'bz;
  assign scl = s_scl_low ? 1'b0 : 1'bz;

  i2c_eeprom_master dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .rw_i(rw), .ur_i(ur),
    .devadr_i(devadr), .regadr_i(regadr), .datnum_i(datnum), .dat_i(dat_i),
    .dat_o(dat_o), .busy_o(busy), .deverr_o(deverr), .dvalid_o(dvalid),
    .newdat_o(newdat), .scl(scl), .sda(sda)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, newdat_cnt = 0, dvalid_cnt = 0;
  int exp_tok[$];
  logic [7:0] exp_dat[$];
  logic [7:0] wr_q[$];
  logic [7:0] s_rdq[$];
  bit   pend = 0;
  bit   s_mon = 1, s_active = 0, s_is_addr = 0, s_rd = 0, s_mnack = 0, s_present = 1;
  bit   s_stretch_arm = 0;
  int   s_bit = 0, s_stretch = 0;
  logic [7:0] s_byte = '0, s_tx = '0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic log_tok(input int tok);
    if (exp_tok.size() > 0) chk("bus token", tok, exp_tok.pop_front());
    else chk("bus token beyond scoreboard", tok, 32'hFFFF);
  endtask

  // One clock of bench time: supply dat_i, score dvalid, run the slave on sampled bus levels
  task automatic tick();
    logic cs, cd;
    int   idx;
    @(negedge clk);
    cyc++;
    if (pend) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      dat_i = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
      pend  = 0;
    end
    if (newdat === 1'b1) begin newdat_cnt++; pend = 1; end
    if (dvalid === 1'b1) begin
      dvalid_cnt++;
      if (exp_dat.size() > 0) chk("dat_o", dat_o, exp_dat.pop_front());
      else chk("dvalid beyond scoreboard", dvalid, 0);
    end
    cs = (scl !== 1'b0);
    cd = (sda !== 1'b0);
    if (s_stretch > 0) begin
      s_stretch--;
      if (s_stretch == 0) s_scl_low = 1'b0;
    end
    if (s_mon) begin
      if (prev_scl && cs && prev_sda && !cd) begin
        log_tok(T_S);
        s_active = 1; s_bit = 0; s_is_addr = 1; s_mnack = 0;
      end else if (prev_scl && cs && !prev_sda && cd) begin
        log_tok(T_P);
        s_active = 0; s_sda_low = 1'b0;
      end else if (s_active && !prev_scl && cs) begin
        if (s_bit < 8) begin
          if (s_is_addr || !s_rd) begin
            s_byte = {s_byte[6:0], cd};
            if (s_bit == 7) begin
              log_tok(int'(s_byte));
              if (s_is_addr) s_rd = s_byte[0];
            end
          end
        end else begin
          if (s_rd && !s_is_addr) begin
            log_tok(cd ? T_NACK : T_ACK);
            s_mnack = cd;
          end
          s_is_addr = 0;
        end
        s_bit = (s_bit == 8) ? 0 : s_bit + 1;
      end else if (s_active && prev_scl && !cs) begin
        s_sda_low = 1'b0;
        if (s_bit == 8) begin
          if (s_is_addr || !s_rd) s_sda_low = s_present;
        end else if (s_rd && !s_is_addr && !s_mnack) begin
          if (s_bit == 0) s_tx = (s_rdq.size() > 0) ? s_rdq.pop_front() : 8'hFF;
          idx = 7 - s_bit;
          s_sda_low = !s_tx[idx];
          if (s_stretch_arm && s_bit == 4) begin
            s_scl_low = 1'b1; s_stretch = 12; s_stretch_arm = 0;
          end
        end
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  endtask

  task automatic run_txn(input logic r, input logic u, input logic [6:0] d, input logic [7:0] g,
                         input logic [4:0] n, output int dur);
    int t0;
    rw = r; ur = u; devadr = d; regadr = g; datnum = n;
    dat_i = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    pend = 0;
    enable = 1'b1;
    t0 = cyc;
    tick();
    chk("busy after enable", busy, 1);
    chk("deverr cleared on accept", deverr, 0);
    enable = 1'b0;
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) tick();
    chk("busy released", busy, 0);
    chk("tokens drained", exp_tok.size(), 0);
    dur = cyc - t0;
  endtask

  initial begin
    int nd0, dv0, dur, d_base;
    rst_n = 1'b0; enable = 1'b0; rw = 1'b0; ur = 1'b0;
    devadr = '0; regadr = '0; datnum = '0; dat_i = '0;
    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset deverr", deverr, 0);
    chk("reset dvalid", dvalid, 0);
    chk("reset newdat", newdat, 0);
    chk("reset dat_o", dat_o, 8'h00);
    chk("reset scl", scl, 1);
    chk("reset sda", sda, 1);
    rst_n = 1'b1;
    repeat (3) tick();

    // Write two bytes
    nd0 = newdat_cnt;
    wr_q = '{8'hA5, 8'h3C};
    exp_tok = '{T_S, 32'hA0, 32'h12, 32'hA5, 32'h3C, T_P};
    run_txn(1'b0, 1'b0, 7'h50, 8'h12, 5'd2, dur);
    chk("write newdat count", newdat_cnt - nd0, 2);
    chk("write deverr", deverr, 0);
    repeat (4) tick();

    // Random read of three bytes
    dv0 = dvalid_cnt;
    s_rdq = '{8'h11, 8'h22, 8'h33};
    exp_dat = '{8'h11, 8'h22, 8'h33};
    exp_tok = '{T_S, 32'hA0, 32'h40, T_S, 32'hA1, T_ACK, T_ACK, T_NACK, T_P};
    run_txn(1'b1, 1'b1, 7'h50, 8'h40, 5'd3, dur);
    chk("rand read dvalid count", dvalid_cnt - dv0, 3);
    chk("rand read last dat_o", dat_o, 8'h33);
    repeat (4) tick();

    // Absent slave on a write
    nd0 = newdat_cnt;
    s_present = 0;
    wr_q = '{8'h77, 8'h88};
    exp_tok = '{T_S, 32'hA0, T_P};
    run_txn(1'b0, 1'b0, 7'h50, 8'h12, 5'd2, dur);
    chk("nack deverr", deverr, 1);
    chk("nack newdat count", newdat_cnt - nd0, 0);
    s_present = 1;
    repeat (4) tick();

    // Current-address read of one byte
    dv0 = dvalid_cnt;
    s_rdq = '{8'h5A};
    exp_dat = '{8'h5A};
    exp_tok = '{T_S, 32'hA1, T_NACK, T_P};
    run_txn(1'b1, 1'b0, 7'h50, 8'h00, 5'd1, d_base);
    chk("cur read dvalid count", dvalid_cnt - dv0, 1);
    chk("cur read dat_o", dat_o, 8'h5A);
    chk("cur read deverr", deverr, 0);
    repeat (4) tick();

    // Reset in the middle of the second data byte
    nd0 = newdat_cnt;
    wr_q = '{8'hA5, 8'h3C, 8'h99};
    exp_tok = '{T_S, 32'hA0, 32'h12, 32'hA5};
    rw = 1'b0; ur = 1'b0; devadr = 7'h50; regadr = 8'h12; datnum = 5'd3;
    dat_i = wr_q[0]; pend = 0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 2000 && newdat_cnt < nd0 + 2; i++) tick();
    chk("second data byte reached", newdat_cnt - nd0, 2);
    repeat (8) tick();
    chk("tokens before abort", exp_tok.size(), 0);
    s_mon = 0;
    rst_n = 1'b0;
    #1;
    chk("abort scl released", scl, 1);
    chk("abort sda released", sda, 1);
    chk("abort busy", busy, 0);
    s_active = 0; s_sda_low = 1'b0;
    tick();
    rst_n = 1'b1;
    nd0 = newdat_cnt; dv0 = dvalid_cnt;
    repeat (40) tick();
    chk("no newdat after abort", newdat_cnt - nd0, 0);
    chk("no dvalid after abort", dvalid_cnt - dv0, 0);
    chk("idle after abort", busy, 0);
    s_mon = 1;
    wr_q = '{8'h77};
    exp_tok = '{T_S, 32'hA0, 32'h12, 32'h77, T_P};
    run_txn(1'b0, 1'b0, 7'h50, 8'h12, 5'd1, dur);
    chk("post-abort newdat count", newdat_cnt - nd0, 1);
    chk("post-abort deverr", deverr, 0);

`ifdef I2C_CLKSTRETCH_EN
    repeat (4) tick();
    s_rdq = '{8'h5A};
    exp_dat = '{8'h5A};
    exp_tok = '{T_S, 32'hA1, T_NACK, T_P};
    s_stretch_arm = 1;
    run_txn(1'b1, 1'b0, 7'h50, 8'h00, 5'd1, dur);
    chk("stretch extension", dur - d_base, 10);
    chk("stretch dat_o", dat_o, 8'h5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
